// File: rtl/pos_stream_ram.sv
// Particle position store: one write port, one registered read port shared by
// random reads and a flow-controlled streaming reader feeding a small FIFO.
module pos_stream_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [3*DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_valid,
  output logic [3*DATA_WIDTH-1:0] rd_data,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     start_count,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    done
);

  localparam int WW = 3 * DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [WW-1:0]         mem [DEPTH];
  logic [WW-1:0]         mem_q;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  mem_ren;
  logic                  rd_accept;
  logic                  rd_p1;
  logic                  s_valid;
  logic [ADDR_WIDTH-1:0] saddr;
  logic [CW-1:0]         issue_left;
  logic [CW-1:0]         beat_left;
  logic [WW-1:0]         fifo [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW:0]           count;
  logic [PW+1:0]         occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Stream reads are credit-limited: buffered beats plus the one read in flight
  // may never exceed the FIFO, so any out_ready pattern is lossless.
  assign occupancy = (PW+2)'(count) + (PW+2)'(s_valid);
  assign issue     = (state == RUN) && (issue_left != '0) &&
                     (occupancy < (PW+2)'(FIFO_DEPTH));
  assign rd_accept = rd_en && !busy && !start;
  assign mem_ren   = issue || rd_accept;
  assign mem_raddr = issue ? saddr : rd_addr;
  assign push      = s_valid;
  assign pop       = out_valid && out_ready;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo[rptr] : '0;
  assign out_last  = out_valid && (beat_left == CW'(1));

  // Read-first storage: a same-cycle write is seen only by later reads.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (mem_ren) mem_q <= mem[mem_raddr];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_p1    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p1    <= rd_accept;
      rd_valid <= rd_p1;
      if (rd_p1) rd_data <= mem_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wptr] <= mem_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      s_valid <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      s_valid <= issue;
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The final accepted beat, not the final read, ends the stream.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      saddr      <= '0;
      issue_left <= '0;
      beat_left  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_count == '0) begin
              done <= 1'b1;
            end else begin
              state      <= RUN;
              busy       <= 1'b1;
              saddr      <= start_addr;
              issue_left <= start_count;
              beat_left  <= start_count;
            end
          end
        end
        RUN: begin
          if (issue) begin
            saddr      <= (saddr == ADDR_WIDTH'(DEPTH-1)) ? '0 : saddr + ADDR_WIDTH'(1);
            issue_left <= issue_left - CW'(1);
            if (issue_left == CW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DRAIN;
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        beat_left <= beat_left - CW'(1);
        if (beat_left == CW'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pos_stream_ram.sv
// Randomized bench for pos_stream_ram against an array-based memory model
// and per-stream expected beat lists.
module tb_pos_stream_ram;

  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int WW    = 3 * DW;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [WW-1:0] rd_data;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   start_count = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          done;

  typedef struct {
    int            due;
    logic [WW-1:0] data;
  } rd_exp_t;

  logic [WW-1:0] model_mem [DEPTH];
  logic [WW-1:0] last_rd;
  rd_exp_t       rd_q[$];
  int            check_count = 0;
  int            pass_count = 0;

  pos_stream_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .start(start), .start_addr(start_addr), .start_count(start_count), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [WW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // mode 0: ready always high, 1: random ready, 2: toggling with a 10-cycle stall
  task automatic runStream(input int sa, input int cnt, input int mode,
                           input int abort_after, input bit poke_busy);
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] prev_data;
    logic          prev_last;
    bit            prev_stall;
    int            beats;
    int            first_valid;
    int            cyc;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) exp_q.push_back(model_mem[(sa + i) % DEPTH]);
    beats = 0;
    first_valid = -1;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 1'b0;
    start = 1'b1;
    start_addr = AW'(sa);
    start_count = (AW+1)'(cnt);
    out_ready = (mode != 1) ? 1'b1 : 1'b0;
    applyStimulus();
    start = 1'b0;
    cyc = 1;
    if (cnt == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
        checkOutput("zero_no_valid", out_valid, 0);
        applyStimulus();
        checkOutput("zero_done_once", done, 0);
      end
      return;
    end
    checkOutput("busy_after_start", busy, 1);
    while (beats < cnt && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 4 && cyc < 14) ? 1'b0 : 1'(cyc % 2);
      endcase
      if (poke_busy && cyc == 2) begin
        rd_en = 1'b1;
        rd_addr = AW'($urandom_range(0, DEPTH-1));
        start = 1'b1;
        start_addr = '0;
        start_count = 5;
      end
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, prev_data);
        checkOutput("stall_last", out_last, prev_last);
      end
      if (first_valid < 0 && out_valid) first_valid = cyc;
      checkOutput("stream_rd_valid", rd_valid, 0);
      checkOutput("early_done", done, 0);
      if (out_valid && out_ready) begin
        checkOutput("beat_data", out_data, exp_q[beats]);
        checkOutput("beat_last", out_last, (beats == cnt - 1) ? 1 : 0);
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      applyStimulus();
      rd_en = 1'b0;
      start = 1'b0;
      cyc++;
      if (abort_after > 0 && beats == abort_after) begin
        rst = 1'b1;
        applyStimulus();
        checkOutput("abort_rd_valid", rd_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_out_last", out_last, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_rd_data", rd_data, 0);
        checkOutput("abort_out_data", out_data, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          applyStimulus();
          checkOutput("post_abort_valid", out_valid, 0);
          checkOutput("post_abort_done", done, 0);
          checkOutput("post_abort_busy", busy, 0);
        end
        return;
      end
    end
    checkOutput("beat_count", beats, cnt);
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_fall", busy, 0);
    if (mode == 0) checkOutput("first_valid_latency", first_valid, 3);
    applyStimulus();
    checkOutput("done_once", done, 0);
    checkOutput("idle_no_valid", out_valid, 0);
  endtask

  initial begin
    applyStimulus();
    applyStimulus();
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_out_data", out_data, 0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = rand_word();
      model_mem[a] = wr_data;
      applyStimulus();
    end

    wr_addr = 5;
    wr_data = {32'd3, 32'd2, 32'd1};
    model_mem[5] = wr_data;
    applyStimulus();
    wr_en = 1'b0;
    rd_en = 1'b1;
    rd_addr = 5;
    applyStimulus();
    rd_en = 1'b0;
    checkOutput("rd_latency_early", rd_valid, 0);
    applyStimulus();
    checkOutput("rd_latency_valid", rd_valid, 1);
    checkOutput("rd_written_value", rd_data, {32'd3, 32'd2, 32'd1});
    last_rd = {32'd3, 32'd2, 32'd1};

    for (int c = 0; c < 83; c++) begin
      if (c < 80) begin
        wr_en = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, DEPTH-1));
        wr_data = rand_word();
        rd_en = 1'($urandom_range(0, 1));
        rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH-1));
      end else begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      if (rd_en) rd_q.push_back('{c + 2, model_mem[rd_addr]});
      if (wr_en) model_mem[wr_addr] = wr_data;
      applyStimulus();
      if (rd_q.size() > 0 && rd_q[0].due == c + 1) begin
        checkOutput("rand_rd_valid", rd_valid, 1);
        checkOutput("rand_rd_data", rd_data, rd_q[0].data);
        last_rd = rd_q[0].data;
        void'(rd_q.pop_front());
      end else begin
        checkOutput("rand_rd_idle", rd_valid, 0);
        checkOutput("rand_rd_hold", rd_data, last_rd);
      end
    end
    checkOutput("rand_rd_drained", rd_q.size(), 0);

    runStream(510, 4, 0, 0, 0);
    runStream(100, 8, 2, 0, 0);
    runStream(20, 0, 0, 0, 0);
    runStream(300, 12, 1, 0, 1);
    runStream(40, 16, 0, 3, 0);
    runStream(40, 16, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      runStream($urandom_range(0, DEPTH-1), $urandom_range(1, 40), 1, 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
